// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one buffered result slot per functional unit,
// round-robin grant, registered broadcast one cycle after acceptance.

module cdb_slot #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr,
  input  logic             gnt,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  output logic             full,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      data
);
  // A refill at the same edge as a grant keeps the slot full.
  always_ff @(posedge clk) begin
    if (clr) begin
      full <= 1'b0;
    end else if (wr) begin
      full <= 1'b1;
      tag  <= wr_tag;
      data <= wr_data;
    end else if (gnt) begin
      full <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = 4,
  parameter int INVALID_TAG = 0,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           FLUSH,
  input  logic [NUM_REQ-1:0]             fu_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_REQ-1:0][31:0]       fu_data,
  output logic [NUM_REQ-1:0]             fu_ready,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [31:0]                    cdb_data,
  output logic [SRC_W-1:0]               cdb_src
);
  localparam logic [TAG_W-1:0] INV = TAG_W'(INVALID_TAG);

  logic                          clr;
  logic [NUM_REQ-1:0]            full, gnt, acc;
  logic [NUM_REQ-1:0][TAG_W-1:0] slot_tag;
  logic [NUM_REQ-1:0][31:0]      slot_data;
  logic [SRC_W-1:0]              rr_ptr, gnt_idx;
  logic                          gnt_any;

  assign clr = RST | FLUSH;

  // First full slot at or after rr_ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && full[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign gnt[i]      = gnt_any && (gnt_idx == SRC_W'(i));
    assign fu_ready[i] = !clr && (!full[i] || gnt[i]);
    // INVALID_TAG offers are dropped without touching the handshake.
    assign acc[i]      = fu_valid[i] && fu_ready[i] && (fu_tag[i] != INV);

    cdb_slot #(.TAG_W(TAG_W)) u_slot (
      .clk     (CLK),
      .clr     (clr),
      .wr      (acc[i]),
      .gnt     (gnt[i]),
      .wr_tag  (fu_tag[i]),
      .wr_data (fu_data[i]),
      .full    (full[i]),
      .tag     (slot_tag[i]),
      .data    (slot_data[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= INV;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (gnt_any) begin
      rr_ptr    <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      cdb_valid <= 1'b1;
      cdb_tag   <= slot_tag[gnt_idx];
      cdb_data  <= slot_data[gnt_idx];
      cdb_src   <= gnt_idx;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= INV;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single offer, round-robin, backpressure,
// grant+refill, flush, mid-stream reset and invalid-tag offers.

module tb_cdb_arbiter;
  logic             CLK = 1'b0;
  logic             RST, FLUSH;
  logic [3:0]       fu_valid;
  logic [3:0][3:0]  fu_tag;
  logic [3:0][31:0] fu_data;
  logic [3:0]       fu_ready;
  logic             cdb_valid;
  logic [3:0]       cdb_tag;
  logic [31:0]      cdb_data;
  logic [1:0]       cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(4), .INVALID_TAG(0)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    fu_valid = '0;
    fu_tag   = '0;
    fu_data  = '0;
  endtask

  task automatic offer(input int i, input logic [3:0] t, input logic [31:0] d);
    fu_valid[i] = 1'b1;
    fu_tag[i]   = t;
    fu_data[i]  = d;
  endtask

  task automatic bcast(input string tag, input logic [3:0] t, input logic [31:0] d,
                       input logic [1:0] s);
    chk({tag, "_valid"}, 32'(cdb_valid), 32'd1);
    chk({tag, "_tag"},   32'(cdb_tag),   32'(t));
    chk({tag, "_data"},  cdb_data,       d);
    chk({tag, "_src"},   32'(cdb_src),   32'(s));
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    chk({tag, "_tag"},   32'(cdb_tag),   32'd0);
    chk({tag, "_data"},  cdb_data,       32'd0);
    chk({tag, "_src"},   32'(cdb_src),   32'd0);
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; idle_in();
    tick(); tick();
    chk("rst_ready_low", 32'(fu_ready), 32'h0);
    quiet("rst");
    RST = 1'b0; #1;
    chk("post_rst_ready", 32'(fu_ready), 32'hF);

    // single offer, one cycle latency
    offer(2, 4'd5, 32'hDEADBEEF); #1;
    chk("single_ready2", 32'(fu_ready[2]), 32'd1);
    tick(); idle_in();
    chk("single_no_bypass", 32'(cdb_valid), 32'd0);
    tick(); bcast("single", 4'd5, 32'hDEADBEEF, 2'd2);
    tick(); quiet("single_after");

    // flush to bring rr_ptr back to 0, then round-robin over four FUs
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) offer(i, 4'(i + 1), 32'h100 + 32'(i));
    tick(); idle_in();
    for (int i = 0; i < 4; i++) begin
      tick(); bcast("rr", 4'(i + 1), 32'h100 + 32'(i), 2'(i));
    end
    tick(); chk("rr_done", 32'(cdb_valid), 32'd0);
    // rr_ptr back at 0: FU0 must win over FU3
    offer(0, 4'd11, 32'hA0); offer(3, 4'd12, 32'hA3);
    tick(); idle_in();
    tick(); bcast("rr_wrap0", 4'd11, 32'hA0, 2'd0);
    tick(); bcast("rr_wrap3", 4'd12, 32'hA3, 2'd3);

    // backpressure on FU1
    offer(0, 4'd7, 32'h70); offer(1, 4'd8, 32'h80);
    tick(); idle_in();
    offer(1, 4'd6, 32'h60); #1;
    chk("bp_stall", 32'(fu_ready[1]), 32'd0);
    tick(); bcast("bp_first", 4'd7, 32'h70, 2'd0);
    chk("bp_accept", 32'(fu_ready[1]), 32'd1);
    tick(); idle_in();
    bcast("bp_second", 4'd8, 32'h80, 2'd1);
    tick(); bcast("bp_held", 4'd6, 32'h60, 2'd1);
    tick(); chk("bp_once", 32'(cdb_valid), 32'd0);

    // simultaneous grant and refill on slot 0
    offer(0, 4'd1, 32'h11); #1;
    chk("refill_rdy1", 32'(fu_ready[0]), 32'd1);
    tick(); offer(0, 4'd2, 32'h22); #1;
    chk("refill_rdy2", 32'(fu_ready[0]), 32'd1);
    tick(); bcast("refill1", 4'd1, 32'h11, 2'd0);
    offer(0, 4'd3, 32'h33); #1;
    chk("refill_rdy3", 32'(fu_ready[0]), 32'd1);
    tick(); idle_in();
    bcast("refill2", 4'd2, 32'h22, 2'd0);
    tick(); bcast("refill3", 4'd3, 32'h33, 2'd0);
    tick(); chk("refill_end", 32'(cdb_valid), 32'd0);

    // flush drops slots 0 and 3
    offer(0, 4'd9, 32'h90); offer(3, 4'd10, 32'hB0);
    tick(); idle_in();
    FLUSH = 1'b1; #1;
    chk("flush_ready_low", 32'(fu_ready), 32'h0);
    tick(); FLUSH = 1'b0; #1;
    quiet("flush");
    chk("flush_ready", 32'(fu_ready), 32'hF);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("flush_silent", 32'(cdb_valid), 32'd0);
    end

    // reset mid-stream, then an INVALID_TAG offer
    for (int i = 0; i < 4; i++) offer(i, 4'(i + 1), 32'h200 + 32'(i));
    tick(); idle_in();
    tick(); bcast("mid", 4'd1, 32'h200, 2'd0);
    RST = 1'b1; tick(); RST = 1'b0;
    quiet("mid_rst");
    offer(1, 4'd0, 32'h1234); #1;
    chk("inv_ready", 32'(fu_ready[1]), 32'd1);
    tick(); idle_in();
    for (int i = 0; i < 4; i++) begin
      tick(); chk("inv_silent", 32'(cdb_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
